// File: rtl/iter_divider.sv
// Iterative 32/32 unsigned restoring divider: one quotient bit per clock, 32 steps.
// Optional DIV_EARLY_OUT_EN: resolves a<b and b==1 at the capture edge and skips the run.
module iter_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        consume,
  output logic        done,
  output logic [63:0] c,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] b_q;
  logic [63:0] c_q;
  logic        done_q;
  logic        busy_q;

  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [63:0] step_d;

  // c_q holds {remainder, quotient}; the quotient half starts as the dividend and
  // is shifted out into the remainder while quotient bits are shifted in.
  always_comb begin
    rem_sh = {c_q[63:32], c_q[31]};
    trial  = rem_sh - {1'b0, b_q};
    step_d = {rem_sh[31:0], c_q[30:0], 1'b0};
    if (rem_sh >= {1'b0, b_q}) begin
      step_d = {trial[31:0], c_q[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid) begin
            b_q   <= b;
            cnt_q <= '0;
`ifdef DIV_EARLY_OUT_EN
            if ((b != '0) && (a < b)) begin
              state_q <= DONE;
              c_q     <= {a, 32'h0};
              done_q  <= 1'b1;
            end else if (b == 32'd1) begin
              state_q <= DONE;
              c_q     <= {32'h0, a};
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              c_q     <= {32'h0, a};
              busy_q  <= 1'b1;
            end
`else
            state_q <= RUN;
            c_q     <= {32'h0, a};
            busy_q  <= 1'b1;
`endif
          end
        end
        RUN: begin
          if (!valid) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            c_q   <= step_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          // Consume and flush both retire the result; a held valid never restarts here.
          if (consume || !valid) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done = done_q;
  assign busy = busy_q;
  assign c    = c_q;

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; forces IDLE immediately.
REQ-003 SHALL have: valid  in  1  divide request, held high by the execute stage until the result is consumed.
REQ-004 SHALL have: a  in  32  unsigned dividend (magnitude; sign handling stays in execute).
REQ-005 SHALL have: b  in  32  unsigned divisor (magnitude).
REQ-006 SHALL have: consume  in  1  execute stage advances past the divide this cycle (~stall).
REQ-007 SHALL have: done  out  1  result valid; registered state decode, no combinational path from inputs.
REQ-008 SHALL have: c  out  64  {remainder[63:32], quotient[31:0]}.
REQ-009 SHALL have: busy  out  1  state is RUN.

Function
REQ-010 SHALL implement states IDLE, RUN, DONE.
REQ-011 IDLE: valid=1 at an edge SHALL capture a, b, clear remainder, set counter=0, enter RUN.
REQ-012 RUN: each edge SHALL perform one restoring step: shift {rem,quot} left 1, trial-subtract b, keep and set quotient bit if no borrow (33-bit compare).
REQ-013 RUN: counter SHALL increment per step; after step 32 (counter wraps 31->0) SHALL enter DONE.
REQ-014 Latency: valid first high in cycle 0 -> done high in cycle 33 (early-out disabled).
REQ-015 a, b SHALL be sampled only at the IDLE->RUN edge; changes during RUN/DONE ignored.
REQ-016 DONE: done=1, c stable; SHALL remain DONE until consume=1 at an edge, then go IDLE.
REQ-017 DONE with consume=1 and valid=1 SHALL still go IDLE (no same-edge restart); next op starts one cycle later.
REQ-018 RUN or DONE with valid=0 at an edge SHALL abort to IDLE without asserting done (pipeline flush).
REQ-019 consume during IDLE or RUN SHALL be ignored.
REQ-020 b=0 SHALL complete normally: quotient 32'hFFFF_FFFF, remainder=a.
REQ-021 c outside DONE SHALL be don't-care for users but SHALL hold its last register value (no X).

Reset
REQ-022 reset=1 SHALL asynchronously set state=IDLE, done=0, busy=0, counter=0, c=64'h0.
REQ-023 reset asserted mid-RUN SHALL discard the operation; after release, valid=1 starts a fresh division.

Configuration
REQ-024 Macro DIV_EARLY_OUT_EN defined: at the IDLE capture edge, if a<b (b nonzero) SHALL go directly to DONE with quotient 0, remainder a; if b=1 SHALL go directly to DONE with quotient a, remainder 0; done in cycle 1.
REQ-025 Macro DIV_EARLY_OUT_EN undefined: every division SHALL take the full 32 RUN steps, latency fixed per REQ-014.

Verification
REQ-026 a=100, b=7, valid held, consume=1 at done -> done in cycle 33, c={32'd2, 32'd14}, IDLE next cycle.
REQ-027 a=32'hFFFF_FFFF, b=0 -> c={32'hFFFF_FFFF, 32'hFFFF_FFFF}, done in cycle 33.
REQ-028 a=50, b=3; consume held 0 for 5 cycles after done -> done and c={2,16} stable all 5 cycles; IDLE after consume.
REQ-029 valid dropped in cycle 10 of a run -> done never asserts, busy=0 in cycle 11; new valid restarts with fresh operands.
REQ-030 reset pulsed in cycle 20 of a run -> done=0, busy=0, c=0 immediately, no edge required.
REQ-031 DIV_EARLY_OUT_EN: a=5, b=9 -> done in cycle 1, c={32'd5, 32'd0}; without macro same result in cycle 33.
